// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned WORD_LEN  = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned BE_WIDTH  = 4;

  localparam logic [BE_WIDTH-1:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    DMEM_CTRL_IDLE   = 2'd0,
    DMEM_CTRL_ACCESS = 2'd1,
    DMEM_CTRL_RMW_WR = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational lane merge: take new bytes where be is set, keep old bytes elsewhere.
module dmem_byte_merge
  import dmem_ctrl_pkg::*;
(
  input  logic [WORD_LEN-1:0] old_word,
  input  logic [WORD_LEN-1:0] new_word,
  input  logic [BE_WIDTH-1:0] be,
  output logic [WORD_LEN-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: arbitrates port A (and port B when DMEM_CTRL_LOADER_EN is
// defined) onto a word-only dmem, turning partial stores into a read-modify-write.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [BE_WIDTH-1:0]  a_be,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_LEN-1:0]  a_wdata,
  output logic [WORD_LEN-1:0]  a_rdata,
  output logic                 a_ack,
`ifdef DMEM_CTRL_LOADER_EN
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [BE_WIDTH-1:0]  b_be,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_LEN-1:0]  b_wdata,
  output logic [WORD_LEN-1:0]  b_rdata,
  output logic                 b_ack,
`endif
  output logic                 mem_we,
  output logic [WORD_LEN-1:0]  mem_addr,
  output logic [WORD_LEN-1:0]  mem_wdata,
  input  logic [WORD_LEN-1:0]  mem_rdata
);

  dmem_state_e state_q, state_d;

  logic                 we_q;
  logic [BE_WIDTH-1:0]  be_q;
  logic [ADDR_SIZE-3:0] addr_q;
  logic [WORD_LEN-1:0]  wdata_q;
  logic [WORD_LEN-1:0]  merge_q;
  logic [WORD_LEN-1:0]  merged;

  logic                 req_any;
  logic                 owner_b;
  logic                 sel_we;
  logic [BE_WIDTH-1:0]  sel_be;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_LEN-1:0]  sel_wdata;
  logic                 start;
  logic                 partial;
  logic                 ack;

  // Grants only happen in IDLE, so a requester still holding req on its ack edge is not re-granted.
  assign start   = (state_q == DMEM_CTRL_IDLE) && req_any;
  assign partial = we_q && (be_q != BE_FULL) && (be_q != '0);

`ifdef DMEM_CTRL_LOADER_EN
  logic owner_q;
  logic prio_q;  // 1: B wins a tie
  logic gnt_b;
  logic [1:0] unused_addr_lsb;

  assign req_any   = a_req | b_req;
  assign gnt_b     = b_req & (~a_req | prio_q);
  assign sel_we    = gnt_b ? b_we    : a_we;
  assign sel_be    = gnt_b ? b_be    : a_be;
  assign sel_addr  = gnt_b ? b_addr  : a_addr;
  assign sel_wdata = gnt_b ? b_wdata : a_wdata;
  assign owner_b   = owner_q;
  assign unused_addr_lsb = a_addr[1:0] ^ b_addr[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= 1'b0;
      prio_q  <= (INIT_PRIO != 0);
    end else if (start) begin
      owner_q <= gnt_b;
      prio_q  <= ~gnt_b;
    end
  end

  assign b_ack   = ack & owner_b;
  assign b_rdata = (ack && owner_b && !we_q) ? mem_rdata : '0;
`else
  logic       unused_init_prio;
  logic [1:0] unused_addr_lsb;

  assign req_any          = a_req;
  assign sel_we           = a_we;
  assign sel_be           = a_be;
  assign sel_addr         = a_addr;
  assign sel_wdata        = a_wdata;
  assign owner_b          = 1'b0;
  assign unused_init_prio = (INIT_PRIO != 0);
  assign unused_addr_lsb  = a_addr[1:0];
`endif

  assign a_ack   = ack & ~owner_b;
  assign a_rdata = (ack && !owner_b && !we_q) ? mem_rdata : '0;

  dmem_byte_merge u_merge (
    .old_word (merge_q),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DMEM_CTRL_IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        we_q    <= sel_we;
        be_q    <= sel_be;
        addr_q  <= sel_addr[ADDR_SIZE-1:2];
        wdata_q <= sel_wdata;
      end
      if (state_q == DMEM_CTRL_ACCESS && partial) merge_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMEM_CTRL_IDLE:   if (req_any) state_d = DMEM_CTRL_ACCESS;
      DMEM_CTRL_ACCESS: state_d = partial ? DMEM_CTRL_RMW_WR : DMEM_CTRL_IDLE;
      DMEM_CTRL_RMW_WR: state_d = DMEM_CTRL_IDLE;
      default:          state_d = DMEM_CTRL_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so reset drops mem_we immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack       = 1'b0;
    mem_addr  = {addr_q, 2'b00};
    unique case (state_q)
      DMEM_CTRL_ACCESS: begin
        ack = ~partial;
        if (we_q && be_q == BE_FULL) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      DMEM_CTRL_RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        ack       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a word-addressed dmem model; the arbitration sequence
// runs only when DMEM_CTRL_LOADER_EN is defined.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 a_req = 1'b0, a_we = 1'b0;
  logic [BE_WIDTH-1:0]  a_be = '0;
  logic [ADDR_SIZE-1:0] a_addr = '0;
  logic [WORD_LEN-1:0]  a_wdata = '0, a_rdata;
  logic                 a_ack;
`ifdef DMEM_CTRL_LOADER_EN
  logic                 b_req = 1'b0, b_we = 1'b0;
  logic [BE_WIDTH-1:0]  b_be = '0;
  logic [ADDR_SIZE-1:0] b_addr = '0;
  logic [WORD_LEN-1:0]  b_wdata = '0, b_rdata;
  logic                 b_ack;
`endif
  logic                 mem_we;
  logic [WORD_LEN-1:0]  mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  dmem_ctrl #(.INIT_PRIO(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_be      (a_be),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_ack     (a_ack),
`ifdef DMEM_CTRL_LOADER_EN
    .b_req     (b_req),
    .b_we      (b_we),
    .b_be      (b_be),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .b_ack     (b_ack),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    int          cyc;
    int          we_cnt;
  } vec_t;

  vec_t vecs [8];

  // One port-A transaction; cycle 1 is the IDLE cycle in which req is first seen.
  task automatic run_a(input vec_t v, output int cyc, output int wecnt, output logic we_at_ack,
                       output logic [31:0] rd);
    logic got;
    @(negedge clk);
    a_req = 1'b1; a_we = v.we; a_be = v.be; a_addr = v.addr; a_wdata = v.wdata;
    cyc = 1; wecnt = mem_we ? 1 : 0; we_at_ack = 1'b0; rd = '0; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_we) wecnt++;
      if (a_ack) begin
        got = 1'b1; rd = a_rdata; we_at_ack = mem_we;
      end
    end
    if (!got) cyc = 99;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cyc, wecnt;
    logic        wea;
    logic [31:0] rd;

    vecs[0] = '{1'b0, 4'hF, 32'h40, 32'h0,        32'h11223344, 32'h11223344, 32'h11223344, 2, 0};
    vecs[1] = '{1'b1, 4'hF, 32'h80, 32'hDEADBEEF, 32'h00000000, 32'h0,        32'hDEADBEEF, 2, 1};
    vecs[2] = '{1'b1, 4'h2, 32'h84, 32'h0000AA00, 32'h11223344, 32'h0,        32'h1122AA44, 3, 1};
    vecs[3] = '{1'b1, 4'h0, 32'h88, 32'hFFFFFFFF, 32'h55667788, 32'h0,        32'h55667788, 2, 0};
    vecs[4] = '{1'b1, 4'hC, 32'h8C, 32'h12345678, 32'hAABBCCDD, 32'h0,        32'h1234CCDD, 3, 1};
    vecs[5] = '{1'b1, 4'h1, 32'h91, 32'h000000EE, 32'hCAFEF00D, 32'h0,        32'hCAFEF0EE, 3, 1};
    vecs[6] = '{1'b1, 4'hA, 32'h94, 32'hA0B0C0D0, 32'h01020304, 32'h0,        32'hA002C004, 3, 1};
    vecs[7] = '{1'b0, 4'hF, 32'h97, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 2, 0};

    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ack", {31'b0, a_ack}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem[vecs[i].addr[9:2]] = vecs[i].pre;
      run_a(vecs[i], cyc, wecnt, wea, rd);
      check($sformatf("v%0d_latency", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_we_count", i), wecnt, vecs[i].we_cnt);
      check($sformatf("v%0d_we_at_ack", i), {31'b0, wea}, vecs[i].we_cnt);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_mem", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
      check($sformatf("v%0d_ack_pulse", i), {31'b0, a_ack}, 32'h0);
    end

    // Reset asserted during RMW_WR: write must vanish at once and memory stay intact.
    mem[8'h28] = 32'h11223344;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_be = 4'h2; a_addr = 32'hA0; a_wdata = 32'h0000AA00;
    @(posedge clk); #1;
    check("rmw_access_we", {31'b0, mem_we}, 32'h0);
    check("rmw_access_ack", {31'b0, a_ack}, 32'h0);
    @(posedge clk); #1;
    check("rmw_wr_we", {31'b0, mem_we}, 32'h1);
    rstn = 1'b0;
    #1;
    check("rst_mid_we", {31'b0, mem_we}, 32'h0);
    check("rst_mid_ack", {31'b0, a_ack}, 32'h0);
    a_req = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack_after", {31'b0, a_ack}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    check("rst_mid_mem", mem[8'h28], 32'h11223344);

`ifdef DMEM_CTRL_LOADER_EN
    begin
      int na = 0, nb = 0, n = 0;
      logic a_next = 1'b0, b_next = 1'b0;
      for (int k = 0; k < 3; k++) begin
        mem[8'h40 + k] = 32'hA0000000 + k;
        mem[8'h80 + k] = 32'hB0000000 + k;
      end
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = 32'h100;
      b_req = 1'b1; b_we = 1'b0; b_be = 4'hF; b_addr = 32'h200;
      for (int c = 0; c < 40 && n < 6; c++) begin
        @(posedge clk); #1;
        if (a_next) begin
          a_next = 1'b0;
          if (na == 3) a_req = 1'b0;
          else a_addr = 32'h100 + 4 * na;
        end
        if (b_next) begin
          b_next = 1'b0;
          if (nb == 3) b_req = 1'b0;
          else b_addr = 32'h200 + 4 * nb;
        end
        if (a_ack && b_ack) check("ack_overlap", 32'h1, 32'h0);
        if (a_ack) begin
          check($sformatf("order_%0d", n), 32'h0, n % 2);
          check($sformatf("arb_a_rdata_%0d", na), a_rdata, 32'hA0000000 + na);
          na++; n++; a_next = 1'b1;
        end else if (b_ack) begin
          check($sformatf("order_%0d", n), 32'h1, n % 2);
          check($sformatf("arb_b_rdata_%0d", nb), b_rdata, 32'hB0000000 + nb);
          nb++; n++; b_next = 1'b1;
        end
      end
      check("arb_done", n, 6);
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
    end
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
